gamepad_reader: RTL and testbench

Serial game-controller front end for the pong core: periodically latches an NES-style 8-button pad, clocks its shift register out over the `pad_latch`/`pad_clk`/`pad_data` wires, and presents debounced, active-high button state to the game logic. It is the input-side counterpart of the pong video path. It sits between the dedicated input pins and the paddle-control logic inside `pong`.

---
 rtl/pong_pkg.sv | 13 +
 rtl/sync2.sv | 14 +
 rtl/gamepad_reader.sv | 87 ++++++++
 tb/tb_gamepad_reader.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared constants and types for the pong core's gamepad front end.
package pong_pkg;
   localparam int GAMEPAD_BITS = 8;
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   typedef enum logic [2:0] {ST_IDLE, ST_LATCH, ST_LOW, ST_HIGH, ST_DONE} pad_state_e;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous single-bit input.
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk)
      if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/gamepad_reader.sv
// gamepad_reader: polls an NES-style pad over latch/clk/data and presents active-high buttons.
// Define GAMEPAD_DEBOUNCE_EN to accept a read only when it matches the previous raw read.
module gamepad_reader
   import pong_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int POLL_DIV = 400000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic                    pad_data,
   output logic                    pad_latch,
   output logic                    pad_clk,
   output logic [GAMEPAD_BITS-1:0] buttons,
   output logic                    buttons_valid
);
   localparam int PW = $clog2(POLL_DIV);
   localparam int TW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] POLL_MAX = PW'(POLL_DIV - 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
   if (CLK_DIV < 4) begin : g_bad_clk_div
      $error("gamepad_reader: CLK_DIV must be at least 4");
   end
   if (POLL_DIV < 18 * CLK_DIV) begin : g_bad_poll_div
      $error("gamepad_reader: POLL_DIV must be at least 18*CLK_DIV");
   end
   pad_state_e state, state_n;
   logic [PW-1:0] poll_cnt;
   logic [TW-1:0] tick_cnt;
   logic [2:0] bit_idx;
   logic [GAMEPAD_BITS-1:0] shift;
   logic data_sync, tick_end;
   // Idle level of an absent pad is high, so the synchronizer resets to "released".
   sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(pad_data), .q(data_sync));
   assign tick_end = tick_cnt == TICK_MAX;
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  state_n = (poll_cnt == POLL_MAX && ena) ? ST_LATCH : ST_IDLE;
         ST_LATCH: state_n = (tick_end && bit_idx[0]) ? ST_LOW : ST_LATCH;
         ST_LOW:   state_n = !tick_end ? ST_LOW : (bit_idx == 3'd7) ? ST_DONE : ST_HIGH;
         ST_HIGH:  state_n = tick_end ? ST_LOW : ST_HIGH;
         default:  state_n = ST_IDLE;
      endcase
   end
   // During LATCH, bit_idx[0] counts the two latch ticks before bit sampling starts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         poll_cnt      <= '0;
         tick_cnt      <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         pad_latch     <= 1'b0;
         pad_clk       <= 1'b0;
         buttons_valid <= 1'b0;
      end else begin
         state         <= state_n;
         poll_cnt      <= (poll_cnt == POLL_MAX) ? '0 : poll_cnt + 1'b1;
         tick_cnt      <= (state == ST_IDLE || tick_end) ? '0 : tick_cnt + 1'b1;
         bit_idx       <= (state == ST_IDLE || (state == ST_LATCH && tick_end && bit_idx[0])) ? '0 :
                          (tick_end && (state == ST_LATCH || state == ST_HIGH)) ? bit_idx + 1'b1 : bit_idx;
         pad_latch     <= state_n == ST_LATCH;
         pad_clk       <= state_n == ST_HIGH;
         buttons_valid <= state == ST_DONE;
         if (state == ST_LOW && tick_end) shift[bit_idx] <= ~data_sync;
      end
   end
`ifdef GAMEPAD_DEBOUNCE_EN
   logic [GAMEPAD_BITS-1:0] raw;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         raw     <= '0;
         buttons <= '0;
      end else if (state == ST_DONE) begin
         raw     <= shift;
         buttons <= (shift == raw) ? shift : buttons;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) buttons <= '0;
      else if (state == ST_DONE) buttons <= shift;
   end
`endif
endmodule

// File: tb/tb_gamepad_reader.sv
// tb_gamepad_reader: randomized pad reads checked against a behavioural button model.
module tb_gamepad_reader;
   localparam int CLK_DIV = 4;
   localparam int POLL_DIV = 100;
   localparam int TXN = 17 * CLK_DIV + 1;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b0;
   logic pad_data, pad_latch, pad_clk, buttons_valid;
   logic [7:0] buttons;
   logic [7:0] pad_btn = 8'h00;
   logic [7:0] pad_reg = 8'h00;
   logic pad_connected = 1'b1;
   logic [7:0] m_raw = 8'h00;
   logic [7:0] m_btn = 8'h00;
   int checks = 0;
   int failures = 0;

   gamepad_reader #(.CLK_DIV(CLK_DIV), .POLL_DIV(POLL_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .pad_data(pad_data),
      .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons), .buttons_valid(buttons_valid)
   );

   always #5 clk = ~clk;

   // Pad: 4021-style register, parallel load on latch, shift on pad_clk rise, active-low output.
   always @(posedge pad_clk or posedge pad_latch)
      pad_reg <= pad_latch ? pad_btn : {1'b0, pad_reg[7:1]};
   assign pad_data = pad_connected ? ~pad_reg[0] : 1'b1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_read(input logic [7:0] r);
`ifdef GAMEPAD_DEBOUNCE_EN
      if (r == m_raw) m_btn = r;
      m_raw = r;
`else
      m_btn = r;
`endif
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      m_raw = 8'h00;
      m_btn = 8'h00;
   endtask

   task automatic wait_latch(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (pad_latch) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic observe_txn(output int lat_hi, output int valid_at, output int rises,
                              output int bad_hi, output int overlap);
      int hi;
      logic prev;
      lat_hi = 1; valid_at = -1; rises = 0; bad_hi = 0; overlap = 0; hi = 0; prev = 1'b0;
      for (int k = 1; k <= TXN + 20; k++) begin
         step();
         if (pad_latch) lat_hi++;
         if (pad_latch && pad_clk) overlap++;
         if (pad_clk) begin
            if (!prev) rises++;
            hi++;
         end else begin
            if (prev && hi != CLK_DIV) bad_hi++;
            hi = 0;
         end
         prev = pad_clk;
         if (buttons_valid) begin
            valid_at = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      ena = 1'b1;
      rst_n = 1'b0;
      repeat (2) step();
      checks++;
      if ({pad_latch, pad_clk, buttons_valid} !== 3'b000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=000", {pad_latch, pad_clk, buttons_valid});
      end
      checks++;
      if (buttons !== 8'h00) begin
         failures++;
         $display("FAIL reset_buttons got=%h exp=00", buttons);
      end
   endtask

   task automatic test_first_latch();
      int n, lat_hi, valid_at, rises, bad_hi, overlap;
      pad_connected = 1'b1;
      ena = 1'b1;
      pad_btn = 8'h81;
      apply_reset();
      wait_latch(POLL_DIV + 50, n);
      checks++;
      if (n !== POLL_DIV) begin
         failures++;
         $display("FAIL first_latch_cycle got=%0d exp=%0d", n, POLL_DIV);
      end
      observe_txn(lat_hi, valid_at, rises, bad_hi, overlap);
      model_read(8'h81);
      checks++;
      if (lat_hi !== 2 * CLK_DIV) begin
         failures++;
         $display("FAIL latch_width got=%0d exp=%0d", lat_hi, 2 * CLK_DIV);
      end
      checks++;
      if (valid_at !== TXN) begin
         failures++;
         $display("FAIL valid_latency got=%0d exp=%0d", valid_at, TXN);
      end
      checks++;
      if (buttons !== m_btn) begin
         failures++;
         $display("FAIL first_read got=%h exp=%h", buttons, m_btn);
      end
      checks++;
      if (rises !== 7 || bad_hi !== 0 || overlap !== 0) begin
         failures++;
         $display("FAIL waveform rises=%0d bad_hi=%0d overlap=%0d exp=7/0/0", rises, bad_hi, overlap);
      end
      step();
      checks++;
      if (buttons_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_pulse_width got=%b exp=0", buttons_valid);
      end
   endtask

   task automatic test_back_to_back();
      int n, lat_hi, valid_at, rises, bad_hi, overlap;
      logic [7:0] prev;
      prev = 8'h81;
      for (int i = 0; i < 6; i++) begin
         pad_btn = (i % 2 == 1) ? prev : 8'($urandom);
         prev = pad_btn;
         wait_latch(POLL_DIV + 50, n);
         checks++;
         if (n !== POLL_DIV - TXN - 1) begin
            failures++;
            $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", i, n, POLL_DIV - TXN - 1);
         end
         observe_txn(lat_hi, valid_at, rises, bad_hi, overlap);
         model_read(pad_btn);
         checks++;
         if (buttons !== m_btn || valid_at !== TXN) begin
            failures++;
            $display("FAIL b2b_read[%0d] got=%h@%0d exp=%h@%0d", i, buttons, valid_at, m_btn, TXN);
         end
         checks++;
         if (rises !== 7 || bad_hi !== 0 || overlap !== 0) begin
            failures++;
            $display("FAIL b2b_wave[%0d] rises=%0d bad_hi=%0d overlap=%0d exp=7/0/0", i, rises, bad_hi, overlap);
         end
         step();
      end
   endtask

   task automatic test_ena_low();
      int n, t, lat_seen, val_seen, lat_hi, valid_at, rises, bad_hi, overlap;
      ena = 1'b0;
      pad_connected = 1'b1;
      pad_btn = 8'h5a;
      apply_reset();
      t = 500 + int'($urandom_range(0, 80));
      lat_seen = 0;
      val_seen = 0;
      for (int i = 0; i < t; i++) begin
         step();
         if (pad_latch) lat_seen++;
         if (buttons_valid) val_seen++;
      end
      checks++;
      if (lat_seen !== 0 || val_seen !== 0 || buttons !== 8'h00) begin
         failures++;
         $display("FAIL ena_low latch=%0d valid=%0d buttons=%h exp=0/0/00", lat_seen, val_seen, buttons);
      end
      ena = 1'b1;
      pad_btn = 8'($urandom);
      wait_latch(2 * POLL_DIV, n);
      checks++;
      if (n !== (t / POLL_DIV + 1) * POLL_DIV - t) begin
         failures++;
         $display("FAIL ena_rise_latch got=%0d exp=%0d", n, (t / POLL_DIV + 1) * POLL_DIV - t);
      end
      observe_txn(lat_hi, valid_at, rises, bad_hi, overlap);
      model_read(pad_btn);
      checks++;
      if (buttons !== m_btn || valid_at !== TXN) begin
         failures++;
         $display("FAIL ena_read got=%h@%0d exp=%h@%0d", buttons, valid_at, m_btn, TXN);
      end
   endtask

   task automatic test_reset_mid();
      int n, lat_hi, valid_at, rises, bad_hi, overlap, seen;
      logic prev;
      ena = 1'b1;
      pad_connected = 1'b1;
      pad_btn = 8'($urandom) | 8'h01;
      apply_reset();
      for (int r = 0; r < 2; r++) begin
         wait_latch(POLL_DIV + 50, n);
         observe_txn(lat_hi, valid_at, rises, bad_hi, overlap);
      end
      pad_btn = ~pad_btn;
      wait_latch(POLL_DIV + 50, n);
      seen = 0;
      prev = 1'b0;
      for (int i = 0; i < TXN && seen < 3; i++) begin
         step();
         if (pad_clk && !prev) seen++;
         prev = pad_clk;
      end
      step();
      rst_n = 1'b0;
      step();
      checks++;
      if ({pad_latch, pad_clk, buttons_valid} !== 3'b000 || buttons !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid got=%b/%h exp=000/00", {pad_latch, pad_clk, buttons_valid}, buttons);
      end
      rst_n = 1'b1;
      m_raw = 8'h00;
      m_btn = 8'h00;
      pad_btn = 8'($urandom);
      for (int r = 0; r < 2; r++) begin
         wait_latch(POLL_DIV + 50, n);
         observe_txn(lat_hi, valid_at, rises, bad_hi, overlap);
         model_read(pad_btn);
         checks++;
         if (buttons !== m_btn || valid_at !== TXN) begin
            failures++;
            $display("FAIL post_reset_read[%0d] got=%h@%0d exp=%h@%0d", r, buttons, valid_at, m_btn, TXN);
         end
      end
   endtask

   task automatic test_debounce_seq();
      int n, lat_hi, valid_at, rises, bad_hi, overlap;
      logic [7:0] seq [3];
      logic [7:0] exp [3];
      seq = '{8'h10, 8'h20, 8'h20};
`ifdef GAMEPAD_DEBOUNCE_EN
      exp = '{8'h00, 8'h00, 8'h20};
`else
      exp = '{8'h10, 8'h20, 8'h20};
`endif
      ena = 1'b1;
      pad_connected = 1'b1;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         pad_btn = seq[i];
         wait_latch(POLL_DIV + 50, n);
         observe_txn(lat_hi, valid_at, rises, bad_hi, overlap);
         checks++;
         if (buttons !== exp[i] || valid_at !== TXN) begin
            failures++;
            $display("FAIL debounce_seq[%0d] got=%h@%0d exp=%h@%0d", i, buttons, valid_at, exp[i], TXN);
         end
      end
   endtask

   task automatic test_disconnected();
      int n, lat_hi, valid_at, rises, bad_hi, overlap;
      ena = 1'b1;
      pad_connected = 1'b0;
      pad_btn = 8'hff;
      apply_reset();
      wait_latch(POLL_DIV + 50, n);
      observe_txn(lat_hi, valid_at, rises, bad_hi, overlap);
      checks++;
      if (buttons !== 8'h00 || valid_at !== TXN) begin
         failures++;
         $display("FAIL absent_read got=%h@%0d exp=00@%0d", buttons, valid_at, TXN);
      end
      for (int r = 0; r < 3; r++) begin
         n = -1;
         for (int i = 1; i <= 2 * POLL_DIV; i++) begin
            step();
            if (buttons_valid) begin
               n = i;
               break;
            end
         end
         checks++;
         if (n !== POLL_DIV || buttons !== 8'h00) begin
            failures++;
            $display("FAIL absent_period[%0d] got=%0d/%h exp=%0d/00", r, n, buttons, POLL_DIV);
         end
      end
      pad_connected = 1'b1;
   endtask

   initial begin
      test_reset();
      test_first_latch();
      test_back_to_back();
      test_ena_low();
      test_reset_mid();
      test_debounce_seq();
      test_disconnected();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
